// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: op codes, FSM encoding, op width.
// Pure declarations; no latency or backpressure of its own.
package usr_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_NOP   = 3'd0;
    localparam op_t OP_LOAD  = 3'd1;
    localparam op_t OP_SHL   = 3'd2;
    localparam op_t OP_SHR   = 3'd3;
    localparam op_t OP_ROL   = 3'd4;
    localparam op_t OP_ROR   = 3'd5;
    localparam op_t OP_ASR   = 3'd6;
    localparam op_t OP_CLEAR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Ops that take a step count and walk through SHIFT.
    function automatic logic is_step_op(op_t op);
        return (op >= OP_SHL) && (op <= OP_ASR);
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Single-step shift/rotate datapath; op 6 is ASR only when USR_ARITH_SHIFT_EN is defined.
// Latency: combinational. Backpressure: none.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  op_t              op,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] d_nxt,
    output logic             dep_bit
);

    always_comb begin
        d_nxt   = d;
        dep_bit = 1'b0;
        case (op)
            OP_SHL: begin
                d_nxt   = {d[WIDTH-2:0], ser_in_l};
                dep_bit = d[WIDTH-1];
            end
            OP_SHR: begin
                d_nxt   = {ser_in_r, d[WIDTH-1:1]};
                dep_bit = d[0];
            end
            OP_ROL: begin
                d_nxt   = {d[WIDTH-2:0], d[WIDTH-1]};
                dep_bit = d[WIDTH-1];
            end
            OP_ROR: begin
                d_nxt   = {d[0], d[WIDTH-1:1]};
                dep_bit = d[0];
            end
`ifdef USR_ARITH_SHIFT_EN
            OP_ASR: begin
                d_nxt   = {d[WIDTH-1], d[WIDTH-1:1]};
                dep_bit = d[0];
            end
`else
            OP_ASR: begin
                d_nxt   = {ser_in_r, d[WIDTH-1:1]};
                dep_bit = d[0];
            end
`endif
            default: begin
                d_nxt   = d;
                dep_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_register_p.sv
// Command-driven WIDTH-bit shift register (load/clear/shift/rotate/ASR via USR_ARITH_SHIFT_EN).
// Latency: 1-cycle ops busy 1 cycle, N-step ops busy N+1 cycles. Commands only taken in IDLE; never queued.
module universal_shift_register_p
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_t              op_q, op_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_vld_q, ser_vld_d;

    logic [WIDTH-1:0] step_d;
    logic             step_bit;
    logic             accept;

    usr_shift_step #(.WIDTH(WIDTH)) u_step (
        .d        (data_q),
        .op       (op_q),
        .ser_in_l (ser_in_l),
        .ser_in_r (ser_in_r),
        .d_nxt    (step_d),
        .dep_bit  (step_bit)
    );

    assign accept = cmd_valid && (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            cnt_q     <= '0;
            op_q      <= OP_NOP;
            ser_out_q <= 1'b0;
            ser_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            ser_out_q <= ser_out_d;
            ser_vld_q <= ser_vld_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        ser_out_d = ser_out_q;
        ser_vld_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_DONE;
                    if (cmd_op == OP_LOAD) begin
                        data_d = load_data;
                    end else if (cmd_op == OP_CLEAR) begin
                        data_d = '0;
                    end else if (is_step_op(cmd_op) && (cmd_count != '0)) begin
                        op_d    = cmd_op;
                        cnt_d   = cmd_count;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                data_d    = step_d;
                ser_out_d = step_bit;
                ser_vld_d = 1'b1;
                cnt_d     = cnt_q - CNT_W'(1);
                // The edge performing the final step also moves to DONE.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready     = (state_q == ST_IDLE);
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_DONE);
        data_out      = data_q;
        ser_out       = ser_out_q;
        ser_out_valid = ser_vld_q;
    end

endmodule

// File: tb/tb_universal_shift_register_p.sv
// Randomised and directed bench for universal_shift_register_p (WIDTH=8, CNT_W=4) against an arithmetic model.
module tb_universal_shift_register_p;

    localparam int W   = 8;
    localparam int CW  = 4;
    localparam int TOP = 1 << (W - 1);
    localparam int MOD = 1 << W;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [CW-1:0] cmd_count = '0;
    logic [W-1:0]  load_data = '0;
    logic          ser_in_l = 1'b0;
    logic          ser_in_r = 1'b0;
    logic [W-1:0]  data_out;
    logic          ser_out;
    logic          ser_out_valid;
    logic          busy;
    logic          done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [W-1:0] obs_d[$];
    logic         obs_s[$];
    int           ready_low;
    int           done_cnt;
    int           done_at;
    logic [W-1:0] acc_data;
    int           model_d = 0;

    universal_shift_register_p #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_count     (cmd_count),
        .load_data     (load_data),
        .ser_in_l      (ser_in_l),
        .ser_in_r      (ser_in_r),
        .data_out      (data_out),
        .ser_out       (ser_out),
        .ser_out_valid (ser_out_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Behavioural step: register treated as an unsigned integer in [0, 2^W).
    function automatic int mstep(input int op, input int d, input int sil, input int sir, output int b);
        int r;
        r = d;
        b = 0;
        case (op)
            2: begin b = d / TOP; r = (d * 2) % MOD + sil; end
            3: begin b = d % 2;   r = d / 2 + sir * TOP; end
            4: begin b = d / TOP; r = (d * 2) % MOD + d / TOP; end
            5: begin b = d % 2;   r = d / 2 + (d % 2) * TOP; end
`ifdef USR_ARITH_SHIFT_EN
            6: begin b = d % 2;   r = d / 2 + (d / TOP) * TOP; end
`else
            6: begin b = d % 2;   r = d / 2 + sir * TOP; end
`endif
            default: begin b = 0; r = d; end
        endcase
        return r;
    endfunction

    // Drives one command from IDLE and records what the DUT does until cmd_ready returns.
    task automatic do_cmd(input int op, input int n, input int ld, input int sil, input int sir);
        int cyc;
        obs_d.delete();
        obs_s.delete();
        ready_low = 0;
        done_cnt  = 0;
        done_at   = -1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_count = CW'(n);
        load_data = W'(ld);
        ser_in_l  = 1'(sil);
        ser_in_r  = 1'(sir);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        acc_data  = data_out;
        cyc = 0;
        while (!cmd_ready && cyc < 100) begin
            ready_low++;
            if (ser_out_valid) begin
                obs_d.push_back(data_out);
                obs_s.push_back(ser_out);
            end
            if (done) begin
                done_cnt++;
                done_at = cyc;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        if (cyc >= 100) begin
            total_cnt++;
            $display("FAIL timeout op=%0d: cmd_ready never returned", op);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({data_out, cmd_ready, busy, done, ser_out, ser_out_valid} !== {8'h00, 5'b10000})
            $display("FAIL reset_vals: got d=%h rdy=%b busy=%b done=%b so=%b sov=%b, want 00 1 0 0 0 0",
                     data_out, cmd_ready, busy, done, ser_out, ser_out_valid);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({data_out, cmd_ready, busy, done} !== {8'h00, 3'b100})
            $display("FAIL reset_release: got d=%h rdy=%b busy=%b done=%b, want 00 1 0 0",
                     data_out, cmd_ready, busy, done);
        else pass_cnt++;
        model_d = 0;
    endtask

    task automatic test_load();
        do_cmd(1, 0, 'hA5, 0, 0);
        model_d = 'hA5;
        total_cnt++;
        if (acc_data !== 8'hA5) $display("FAIL load_data: got %h want a5", acc_data);
        else pass_cnt++;
        total_cnt++;
        if (ready_low !== 1 || done_cnt !== 1 || done_at !== 0)
            $display("FAIL load_timing: got ready_low=%0d done_cnt=%0d done_at=%0d want 1 1 0",
                     ready_low, done_cnt, done_at);
        else pass_cnt++;
    endtask

    task automatic test_shl_directed();
        logic [W-1:0] exp_d[3];
        logic         exp_s[3];
        exp_d = '{8'h4B, 8'h97, 8'h2F};
        exp_s = '{1'b1, 1'b0, 1'b1};
        do_cmd(2, 3, 0, 1, 0);
        model_d = 'h2F;
        total_cnt++;
        if (obs_d.size() !== 3 || ready_low !== 4 || done_at !== 3 || done_cnt !== 1)
            $display("FAIL shl3_timing: got steps=%0d ready_low=%0d done_at=%0d done_cnt=%0d want 3 4 3 1",
                     obs_d.size(), ready_low, done_at, done_cnt);
        else pass_cnt++;
        for (int i = 0; i < 3 && i < obs_d.size(); i++) begin
            total_cnt++;
            if (obs_d[i] !== exp_d[i] || obs_s[i] !== exp_s[i])
                $display("FAIL shl3_step%0d: got d=%h so=%b want d=%h so=%b",
                         i, obs_d[i], obs_s[i], exp_d[i], exp_s[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_ror_wrap();
        do_cmd(1, 0, 'h81, 0, 0);
        do_cmd(5, 9, 0, 0, 0);
        model_d = 'hC0;
        total_cnt++;
        if (data_out !== 8'hC0 || obs_d.size() !== 9 || ready_low !== 10)
            $display("FAIL ror9: got d=%h pulses=%0d ready_low=%0d want c0 9 10",
                     data_out, obs_d.size(), ready_low);
        else pass_cnt++;
    endtask

    task automatic test_op6();
        logic [W-1:0] want;
`ifdef USR_ARITH_SHIFT_EN
        want = 8'hE4;
`else
        want = 8'h24;
`endif
        do_cmd(1, 0, 'h90, 0, 0);
        do_cmd(6, 2, 0, 0, 0);
        model_d = int'(want);
        total_cnt++;
        if (data_out !== want) $display("FAIL op6: got %h want %h", data_out, want);
        else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        int dones;
        int b;
        int exp;
        exp = model_d;
        for (int i = 0; i < 5; i++) exp = mstep(2, exp, 0, 0, b);
        dones = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_count = 4'd5; ser_in_l = 1'b0;
        @(negedge clk);
        // Hammer a LOAD while the shift is in flight; it must be dropped.
        cmd_op = 3'd1; load_data = 8'hFF; cmd_count = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        total_cnt++;
        if (data_out !== W'(exp) || dones !== 1 || cmd_ready !== 1'b1)
            $display("FAIL busy_ignore: got d=%h dones=%0d rdy=%b want d=%h dones=1 rdy=1",
                     data_out, dones, cmd_ready, W'(exp));
        else pass_cnt++;
        model_d = exp;

        do_cmd(2, 0, 0, 1, 1);
        total_cnt++;
        if (data_out !== W'(model_d) || obs_d.size() !== 0 || ready_low !== 1 || done_at !== 0)
            $display("FAIL shl_n0: got d=%h pulses=%0d ready_low=%0d done_at=%0d want d=%h 0 1 0",
                     data_out, obs_d.size(), ready_low, done_at, W'(model_d));
        else pass_cnt++;

        do_cmd(7, 3, 'h55, 0, 0);
        model_d = 0;
        total_cnt++;
        if (acc_data !== 8'h00 || ready_low !== 1)
            $display("FAIL clear: got d=%h ready_low=%0d want 00 1", acc_data, ready_low);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int op, n, ld, sil, sir, exp, b;
        int exp_d[$];
        int exp_s[$];
        int exp_low;
        for (int k = 0; k < 40; k++) begin
            op  = $urandom_range(0, 7);
            n   = $urandom_range(0, 15);
            ld  = $urandom_range(0, MOD - 1);
            sil = $urandom_range(0, 1);
            sir = $urandom_range(0, 1);
            exp_d.delete();
            exp_s.delete();
            exp = model_d;
            if (op == 1) exp = ld;
            else if (op == 7) exp = 0;
            else if (op >= 2 && op <= 6) begin
                for (int i = 0; i < n; i++) begin
                    exp = mstep(op, exp, sil, sir, b);
                    exp_d.push_back(exp);
                    exp_s.push_back(b);
                end
            end
            exp_low = exp_d.size() + 1;
            do_cmd(op, n, ld, sil, sir);
            model_d = exp;
            total_cnt++;
            if (obs_d.size() !== exp_d.size() || ready_low !== exp_low || done_cnt !== 1 || done_at !== exp_low - 1)
                $display("FAIL rand%0d_timing op=%0d n=%0d: got steps=%0d ready_low=%0d dones=%0d done_at=%0d want %0d %0d 1 %0d",
                         k, op, n, obs_d.size(), ready_low, done_cnt, done_at, exp_d.size(), exp_low, exp_low - 1);
            else pass_cnt++;
            for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
                total_cnt++;
                if (obs_d[i] !== W'(exp_d[i]) || obs_s[i] !== 1'(exp_s[i]))
                    $display("FAIL rand%0d_step%0d op=%0d: got d=%h so=%b want d=%h so=%b",
                             k, i, op, obs_d[i], obs_s[i], W'(exp_d[i]), 1'(exp_s[i]));
                else pass_cnt++;
            end
            total_cnt++;
            if (data_out !== W'(exp))
                $display("FAIL rand%0d_final op=%0d n=%0d: got %h want %h", k, op, n, data_out, W'(exp));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_shift();
        int dones;
        dones = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_count = 4'd10; load_data = 8'h00;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({data_out, cmd_ready, busy, done, ser_out, ser_out_valid} !== {8'h00, 5'b10000})
            $display("FAIL reset_mid: got d=%h rdy=%b busy=%b done=%b so=%b sov=%b, want 00 1 0 0 0 0",
                     data_out, cmd_ready, busy, done, ser_out, ser_out_valid);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        total_cnt++;
        if (dones !== 0 || data_out !== 8'h00)
            $display("FAIL reset_mid_after: got done/busy cycles=%0d d=%h want 0 00", dones, data_out);
        else pass_cnt++;
        model_d = 0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_shl_directed();
        test_ror_wrap();
        test_op6();
        test_busy_ignore();
        do_cmd(1, 0, 'h3C, 0, 0);
        model_d = 'h3C;
        test_random();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/universal_shift_register_p.md
Name: universal_shift_register_p

Overview:
Parametrised successor to the 8-bit universal shift register. Provides a command-driven WIDTH-bit register supporting load, clear, logical shift, rotate and arithmetic shift, with multi-step counted operations. Each step is one clock, with serial in/out per step. A valid/ready command handshake and a one-cycle done pulse make it usable as a sequencer-controlled datapath element, for example in serialisers or bit-banged protocol engines.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of the step-count field; a single command performs at most 2^CNT_W-1 steps

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; a command is accepted on a clk edge where cmd_valid && cmd_ready
cmd_op  in  3  0 NOP, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLEAR
cmd_count  in  CNT_W  number of steps for ops 2..6; ignored for other ops
load_data  in  WIDTH  value for LOAD, sampled at accept
ser_in_l  in  1  bit entering the LSB on SHL, sampled on each step edge
ser_in_r  in  1  bit entering the MSB on SHR, sampled on each step edge
data_out  out  WIDTH  register contents
ser_out  out  1  bit that left the register on the last step (MSB for SHL/ROL, LSB otherwise)
ser_out_valid  out  1  high for one cycle after each step edge
busy  out  1  high in SHIFT or DONE
done  out  1  one-cycle pulse on command completion

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: data_out=0, ser_out=0, ser_out_valid=0, done=0, busy=0, cmd_ready=1, state=IDLE, step counter=0.
- Reset asserted mid-command aborts the command immediately. No done pulse is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, on accept:
  - NOP: no change, go to DONE.
  - LOAD: data_out<=load_data on the accept edge, go to DONE.
  - CLEAR: data_out<=0 on the accept edge, go to DONE.
  - Ops 2..6 with cmd_count=0: no change, go to DONE.
  - Ops 2..6 with cmd_count=N>=1: latch op and N, go to SHIFT.
- SHIFT: one step per edge, N steps total; go to DONE on the edge performing step N.
- Step definitions:
  - SHL: {d[W-2:0],ser_in_l}
  - SHR: {ser_in_r,d[W-1:1]}
  - ROL: {d[W-2:0],d[W-1]}
  - ROR: {d[0],d[W-1:1]}
  - ASR: {d[W-1],d[W-1:1]}
- On every step edge, ser_out is loaded with the departing bit and ser_out_valid is pulsed.
- DONE: done=1 for exactly one cycle, cmd_ready=0; return to IDLE on the next edge.
- Latency: single-cycle ops keep cmd_ready low for 1 cycle. An N-step op keeps cmd_ready low for N+1 cycles. Back-to-back commands are accepted every N+2 cycles.
- cmd_valid while cmd_ready=0 is ignored; the command is not queued. Inputs other than ser_in_* are don't-care outside accept.
- Rotates with N>=WIDTH wrap naturally; there is no modulo shortcut, and N steps are always taken.
- data_out is the live register and changes on every step edge.

Optional Feature:
USR_ARITH_SHIFT_EN
- Defined: op 6 performs ASR as specified above.
- Undefined: op 6 decodes identically to SHR (ser_in_r enters the MSB), and the sign-replication logic is absent.

Decomposition:
- Package usr_pkg holds:
  - op localparams OP_NOP..OP_CLEAR
  - FSM state encoding ST_IDLE/ST_SHIFT/ST_DONE
  - the 3-bit op width constant
- Sub-module usr_shift_step, combinational single-step datapath:
  - inputs: d, op, ser_in_l, ser_in_r
  - outputs: next d, departing bit
  - reused by the top-level FSM.
- The top level holds the FSM, step counter, and output registers.

Test Plan:
- Reset with WIDTH=8 → data_out=0x00, cmd_ready=1, busy=0, done=0. Reset again mid-SHIFT → all outputs return to reset values asynchronously and no done pulse follows.
- LOAD 0xA5 → data_out=0xA5 after the accept edge, done pulses next cycle, cmd_ready back to 1 the following cycle.
- From 0xA5, SHL N=3 with ser_in_l=1:
  - data_out sequence 0x4B, 0x97, 0x2F
  - ser_out sequence 1, 0, 1, each with ser_out_valid
  - cmd_ready low 4 cycles, done after the third step.
- LOAD 0x81, then ROR N=9 → final data_out=0xC0, 9 ser_out_valid pulses.
- LOAD 0x90, then op 6 with N=2, ser_in_r=0 → 0xE4 with USR_ARITH_SHIFT_EN defined, 0x24 without.
- Issue a second command while busy, then SHL N=0 → the in-flight command completes unchanged and the second command is never accepted; N=0 gives done after 1 cycle with data_out unchanged and no ser_out_valid.
